// File: rtl/meter_pkg.sv
// Shared types and defaults for the square-wave period/high-time meter.
package meter_pkg;

  typedef enum logic {IDLE, MEASURE} state_e;

  localparam int unsigned DEF_W           = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned CNT_MAX         = (1 << DEF_W) - 1;

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchroniser plus rising-edge detector; resets to all-ones so a
// line already high at reset release never produces a rise.
module sig_sync_edge
  import meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;

endmodule

// File: rtl/sq_wave_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles,
// pulsing valid once per full period and flagging a stuck input with timeout.
module sq_wave_meter
  import meter_pkg::*;
#(
  parameter int unsigned W           = DEF_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         timeout,
  output logic         busy
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_TOP = '1;

  logic s, rise;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hcnt_q, hcnt_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q, high_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;

  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .s    (s),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end
      end
      MEASURE: begin
        // A rise on the saturating cycle still counts as a measurement.
        if (rise) begin
          period_d  = cnt_q;
          high_d    = hcnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = CNT_ONE;
          hcnt_d    = CNT_ONE;
        end else if (cnt_q == CNT_TOP) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          hcnt_d = hcnt_q + W'(s);
        end
      end
    endcase
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q == MEASURE);

endmodule

// File: doc/sq_wave_meter.md
Name: sq_wave_meter

Overview:
- Receive-side counterpart to the team's square-wave source modules: takes an externally generated square wave and measures its period and high time in clock cycles.
- Synchronises the asynchronous input, detects rising edges, and reports each full period with a one-cycle valid pulse.
- Flags a missing or stuck input with a timeout.
- Used by the benches and by later designs to check generated clock and strobe frequencies.

Parameters:
- W, 16, width of the period and high-time counters and outputs.
- SYNC_STAGES, 2, number of synchroniser flops on sig_in (minimum 2).

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  asynchronous square wave under measurement.
- period  output  W  cycles between the last two rising edges.
- high_time  output  W  cycles sig_in was high within that period.
- valid  output  1  one-cycle pulse; period and high_time updated this cycle.
- timeout  output  1  sticky; no rising edge within 2^W-1 cycles.
- busy  output  1  high while in MEASURE state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - period=0, high_time=0, valid=0, timeout=0, busy=0, state=IDLE, counters=0.
  - All synchroniser flops and the edge-detect flop are set to 1, so no rise is seen until sig_in has been low after reset.
  - Reset mid-measurement discards the partial count; no valid is produced.
- Synchroniser: s = last of SYNC_STAGES flops; prev = s delayed one cycle; rise = s & ~prev (combinational).
  - A 0->1 on sig_in captured at edge n gives rise during the cycle after edge n+SYNC_STAGES-1.
  - The resulting valid is high in the cycle after edge n+SYNC_STAGES.
- Counters: cnt and hcnt, both W bits.
- IDLE state:
  - On rise: go to MEASURE, cnt<=1, hcnt<=1. This first edge arms only; no valid.
  - Otherwise counters hold.
- MEASURE state:
  - On rise: period<=cnt, high_time<=hcnt, valid<=1, cnt<=1, hcnt<=1, timeout<=0.
  - Otherwise: cnt<=cnt+1, hcnt<=hcnt+s, valid<=0.
  - Result: a wave with period P and H high cycles reports period=P, high_time=H.
- Timeout:
  - If cnt==2^W-1 with no rise: timeout<=1, state<=IDLE, no valid.
  - If rise coincides with cnt==2^W-1: rise wins; measure with period=2^W-1, no timeout.
- Counter width:
  - hcnt never exceeds cnt, so it cannot overflow.
  - No wrap-around is possible; cnt saturation always routes to timeout.
- Output hold and clearing:
  - period and high_time hold their last values between valid pulses and through timeout.
  - timeout clears on the next measured period (rise in MEASURE), not on the arming rise.
- Glitch and input-rate rules:
  - Glitches shorter than one clk period may be missed; this is acceptable.
  - An input period of 2 cycles is the minimum measurable value (period=2, high_time=1).
- valid is never high for two consecutive cycles unless sig_in period is exactly 2... is not allowed. Correction: valid may be high on consecutive measurements only at the 2-cycle minimum, and never on adjacent cycles.

Decomposition:
- Shared package meter_pkg holds:
  - state enum {IDLE, MEASURE};
  - localparam CNT_MAX = 2^W-1;
  - default SYNC_STAGES.
- One natural sub-module, sig_sync_edge: the synchroniser plus rise detector, with reset-to-1 behaviour and ports clk, rst, d, s, rise.
- Counters and FSM stay in sq_wave_meter.

Test Plan:
- Bench toggles sig_in every 4 clk cycles (period 8, 50%) -> first valid after the second rise reports period=8, high_time=4; repeats every 8 cycles.
- sig_in high 3 cycles, low 9 cycles -> period=12, high_time=3 on every valid; busy=1 after the first rise.
- W=8, sig_in held low after one rise -> timeout=1 exactly 255 cycles after the arming rise, busy=0, valid never asserted. Then period-6 toggling resumes -> timeout stays 1 through the arming rise and clears with the first valid, which reports period=6.
- sig_in already high when rst releases -> no valid and busy=0 until sig_in has gone low then high; the first valid appears only after the following rise.
- rst pulsed for 1 cycle mid-period during period-8 toggling -> outputs 0 the cycle after reset, the next rise arms only, the first subsequent valid reports period=8.
- sig_in toggling every cycle (period 2) -> valid every second cycle with period=2, high_time=1.
